// File: rtl/allocator_wavefront_rr.sv
// ============================================================================
// Module  : allocator_wavefront_rr
// Brief   : NUM_REQS x NUM_RESS wavefront allocator with rotating priority
//           diagonal and registered grants; ALLOC_LOCK_EN makes grants sticky.
// Revision: 1.0
// ============================================================================
`default_nettype none

module allocator_wavefront_rr #(
    parameter  int NUM_REQS = 4,
    parameter  int NUM_RESS = 4,
    localparam int D        = (NUM_REQS > NUM_RESS) ? NUM_REQS : NUM_RESS,
    localparam int PTR_W    = (D > 1) ? $clog2(D) : 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_REQS-1:0][NUM_RESS-1:0]  requests,
    output logic [NUM_REQS-1:0][NUM_RESS-1:0]  grants,
    output logic                               grant_any,
    output logic [PTR_W-1:0]                   priority_ptr
);

    logic [NUM_REQS-1:0][NUM_RESS-1:0] grants_q, grants_d;
    logic [NUM_REQS-1:0][NUM_RESS-1:0] new_grant;
    logic                              grant_any_q, grant_any_d;
    logic [PTR_W-1:0]                  priority_ptr_q, priority_ptr_d;
    logic [NUM_REQS-1:0]               row_lock, row_free;
    logic [NUM_RESS-1:0]               col_lock, col_free;
    int                                dsel;

`ifdef ALLOC_LOCK_EN
    logic [NUM_REQS-1:0][NUM_RESS-1:0] lock_pairs;

    // A pair held last cycle survives only while its request is still raised.
    always_comb begin
        lock_pairs = grants_q & requests;
        row_lock   = '0;
        col_lock   = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            for (int j = 0; j < NUM_RESS; j++) begin
                if (lock_pairs[i][j]) begin
                    row_lock[i] = 1'b1;
                    col_lock[j] = 1'b1;
                end
            end
        end
    end
`else
    always_comb begin
        row_lock = '0;
        col_lock = '0;
    end
`endif

    // Diagonals are visited in priority order; cells of one diagonal never
    // share a row or column, so visiting them one after another is exact.
    always_comb begin
        row_free  = ~row_lock;
        col_free  = ~col_lock;
        new_grant = '0;
        dsel      = 0;
        for (int k = 0; k < D; k++) begin
            dsel = int'(priority_ptr_q) + k;
            if (dsel >= D) begin
                dsel = dsel - D;
            end
            for (int i = 0; i < NUM_REQS; i++) begin
                for (int j = 0; j < NUM_RESS; j++) begin
                    if ((((i + j) % D) == dsel) && requests[i][j] &&
                        row_free[i] && col_free[j]) begin
                        new_grant[i][j] = 1'b1;
                        row_free[i]     = 1'b0;
                        col_free[j]     = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
`ifdef ALLOC_LOCK_EN
        grants_d = lock_pairs | new_grant;
`else
        grants_d = new_grant;
`endif
        grant_any_d    = |grants_d;
        priority_ptr_d = priority_ptr_q;
        if (|new_grant) begin
            if (priority_ptr_q == PTR_W'(D - 1)) begin
                priority_ptr_d = '0;
            end else begin
                priority_ptr_d = priority_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grants_q       <= '0;
            grant_any_q    <= 1'b0;
            priority_ptr_q <= '0;
        end else begin
            grants_q       <= grants_d;
            grant_any_q    <= grant_any_d;
            priority_ptr_q <= priority_ptr_d;
        end
    end

    assign grants       = grants_q;
    assign grant_any    = grant_any_q;
    assign priority_ptr = priority_ptr_q;

endmodule

`default_nettype wire

// File: tb/tb_allocator_wavefront_rr.sv
// ============================================================================
// Module  : tb_allocator_wavefront_rr
// Brief   : Self-checking bench for allocator_wavefront_rr (4x4 and 2x5 builds).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_allocator_wavefront_rr;

    typedef logic [7:0][7:0] mat_t;

    typedef struct {
        logic [15:0] req;
        logic [15:0] exp_g;
        logic [1:0]  exp_ptr;
        logic        exp_any;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [3:0][3:0]  req4 = '0;
    logic [3:0][3:0]  gnt4;
    logic             any4;
    logic [1:0]       ptr4;
    logic [1:0][4:0]  req25 = '0;
    logic [1:0][4:0]  gnt25;
    logic             any25;
    logic [2:0]       ptr25;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    allocator_wavefront_rr #(.NUM_REQS(4), .NUM_RESS(4)) u_dut4 (
        .clk(clk), .reset(reset), .requests(req4),
        .grants(gnt4), .grant_any(any4), .priority_ptr(ptr4)
    );

    allocator_wavefront_rr #(.NUM_REQS(2), .NUM_RESS(5)) u_dut25 (
        .clk(clk), .reset(reset), .requests(req25),
        .grants(gnt25), .grant_any(any25), .priority_ptr(ptr25)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic mat_t to_mat(input logic [63:0] flat, input int r, input int c);
        mat_t m = '0;
        for (int i = 0; i < r; i++)
            for (int j = 0; j < c; j++)
                m[i][j] = flat[i*c+j];
        return m;
    endfunction

    function automatic logic [63:0] to_flat(input mat_t m, input int r, input int c);
        logic [63:0] f = '0;
        for (int i = 0; i < r; i++)
            for (int j = 0; j < c; j++)
                f[i*c+j] = m[i][j];
        return f;
    endfunction

    // Reference: held pairs first, then greedy over cells ranked by distance
    // of their diagonal from the priority pointer.
    function automatic void model(input int r, input int c, input mat_t req, input mat_t prev,
                                  input int ptr, output mat_t g, output int nptr);
        int  dd;
        bit  rowb[8] = '{default: 1'b0};
        bit  colb[8] = '{default: 1'b0};
        bit  any_new = 1'b0;
        dd = (r > c) ? r : c;
        g  = '0;
`ifdef ALLOC_LOCK_EN
        for (int i = 0; i < r; i++)
            for (int j = 0; j < c; j++)
                if (prev[i][j] && req[i][j]) begin
                    g[i][j] = 1'b1; rowb[i] = 1'b1; colb[j] = 1'b1;
                end
`else
        if (prev != prev) g = '0;
`endif
        for (int rank = 0; rank < dd; rank++)
            for (int i = 0; i < r; i++)
                for (int j = 0; j < c; j++)
                    if (((i + j + dd - ptr) % dd) == rank && req[i][j] && !rowb[i] && !colb[j]) begin
                        g[i][j] = 1'b1; rowb[i] = 1'b1; colb[j] = 1'b1; any_new = 1'b1;
                    end
        nptr = any_new ? (ptr + 1) % dd : ptr;
    endfunction

    // Independent invariant count: one-hot rows/cols, grant implies request, maximal.
    function automatic int violations(input mat_t req, input mat_t g, input int r, input int c);
        int v = 0;
        int rc[8] = '{default: 0};
        int cc[8] = '{default: 0};
        for (int i = 0; i < r; i++)
            for (int j = 0; j < c; j++)
                if (g[i][j]) begin
                    rc[i]++; cc[j]++;
                    if (!req[i][j]) v++;
                end
        for (int i = 0; i < 8; i++) if (rc[i] > 1 || cc[i] > 1) v++;
        for (int i = 0; i < r; i++)
            for (int j = 0; j < c; j++)
                if (req[i][j] && rc[i] == 0 && cc[j] == 0) v++;
        return v;
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        req4  = '0;
        req25 = '0;
        cyc();
        reset = 1'b1;
    endtask

    vec_t tbl[9];
    mat_t m4_g, m25_g, nx_g;
    int   m4_p, m25_p, nx_p;

    initial begin
        // Reset held with every request raised.
        req4  = '1;
        req25 = '1;
        cyc();
        cyc();
        check("rst_grants4", 64'(gnt4), 64'h0);
        check("rst_any4", 64'(any4), 64'h0);
        check("rst_ptr4", 64'(ptr4), 64'h0);
        check("rst_grants25", 64'(gnt25), 64'h0);
        check("rst_ptr25", 64'(ptr25), 64'h0);
        reset = 1'b1;

`ifndef ALLOC_LOCK_EN
        tbl[0] = '{16'hFFFF, 16'h2481, 2'd1, 1'b1};
        tbl[1] = '{16'hFFFF, 16'h4812, 2'd2, 1'b1};
        tbl[2] = '{16'hFFFF, 16'h8124, 2'd3, 1'b1};
        tbl[3] = '{16'h1001, 16'h1000, 2'd0, 1'b1};
        tbl[4] = '{16'h1001, 16'h0001, 2'd1, 1'b1};
        tbl[5] = '{16'h1001, 16'h1000, 2'd2, 1'b1};
        tbl[6] = '{16'h1001, 16'h1000, 2'd3, 1'b1};
        tbl[7] = '{16'h0000, 16'h0000, 2'd3, 1'b0};
        tbl[8] = '{16'h0000, 16'h0000, 2'd3, 1'b0};
        for (int t = 0; t < 9; t++) begin
            req4  = tbl[t].req;
            req25 = '1;
            cyc();
            check($sformatf("tbl%0d_grants", t), 64'(gnt4), 64'(tbl[t].exp_g));
            check($sformatf("tbl%0d_ptr", t), 64'(ptr4), 64'(tbl[t].exp_ptr));
            check($sformatf("tbl%0d_any", t), 64'(any4), 64'(tbl[t].exp_any));
            if (t == 0) check("ns_first_grants", 64'(gnt25), 64'h201);
            check($sformatf("ns%0d_ptr", t), 64'(ptr25), 64'((t + 1) % 5));
        end
`else
        do_reset();
        req4 = 16'h0001;
        cyc();
        check("lk_first_grant", 64'(gnt4), 64'h0001);
        check("lk_first_ptr", 64'(ptr4), 64'd1);
        req4 = 16'h0101;
        for (int t = 0; t < 2; t++) begin
            cyc();
            check($sformatf("lk_hold%0d_grants", t), 64'(gnt4), 64'h0001);
            check($sformatf("lk_hold%0d_ptr", t), 64'(ptr4), 64'd1);
        end
        req4 = 16'h0100;
        cyc();
        check("lk_release_grants", 64'(gnt4), 64'h0100);
        check("lk_release_ptr", 64'(ptr4), 64'd2);
`endif

        // Asynchronous reset in the middle of a burst.
        req4  = '1;
        req25 = '1;
        cyc();
        cyc();
        #1;
        reset = 1'b0;
        #1;
        check("async_grants", 64'(gnt4), 64'h0);
        check("async_any", 64'(any4), 64'h0);
        check("async_ptr", 64'(ptr4), 64'h0);
        #1;
        reset = 1'b1;
        cyc();
        check("post_rst_grants", 64'(gnt4), 64'h2481);
        check("post_rst_ptr", 64'(ptr4), 64'd1);

        // Randomized traffic against the reference model.
        do_reset();
        m4_g = '0; m4_p = 0; m25_g = '0; m25_p = 0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 2) != 0) begin
                req4  = 16'($urandom) & 16'($urandom | $urandom);
                req25 = 10'($urandom) & 10'($urandom);
            end
            cyc();
            model(4, 4, to_mat(64'(req4), 4, 4), m4_g, m4_p, nx_g, nx_p);
            m4_g = nx_g; m4_p = nx_p;
            model(2, 5, to_mat(64'(req25), 2, 5), m25_g, m25_p, nx_g, nx_p);
            m25_g = nx_g; m25_p = nx_p;
            check("rnd4_grants", 64'(gnt4), to_flat(m4_g, 4, 4));
            check("rnd4_ptr", 64'(ptr4), 64'(m4_p));
            check("rnd4_any", 64'(any4), 64'(|m4_g));
            check("rnd4_invariants", 64'(violations(to_mat(64'(req4), 4, 4), to_mat(64'(gnt4), 4, 4), 4, 4)), 64'd0);
            check("rnd25_grants", 64'(gnt25), to_flat(m25_g, 2, 5));
            check("rnd25_ptr", 64'(ptr25), 64'(m25_p));
            check("rnd25_any", 64'(any25), 64'(|m25_g));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
